// File: rtl/fp8_mul_pkg.sv
// Shared widths and tag type for the FP8 multiplier arbiter slice.
// Every block that touches requester ids or result payloads imports these.
package fp8_mul_pkg;

    localparam int OPND_W  = 40;
    localparam int RES_W   = 96;
    localparam int NREQ    = 2;
    localparam int ENTRY_W = RES_W + 1;

    // Travels alongside an operation in the multiplier pipe so the result
    // can be attributed to its requester.
    typedef struct packed {
        logic valid;
        logic id;
    } tag_t;

endpackage

// File: rtl/fp8_resp_fifo.sv
// Response FIFO: DEPTH entries of {id,result}, head presented from flops.
// Push and pop may coincide at any occupancy; the caller never pushes when full.
module fp8_resp_fifo
    import fp8_mul_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               push,
    input  logic [ENTRY_W-1:0] push_data,
    input  logic               pop,
    output logic               head_valid,
    output logic [ENTRY_W-1:0] head_data
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   count;
    logic               do_pop;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign head_valid = (count != '0);
    assign do_pop     = pop & head_valid;
    assign head_data  = head_valid ? mem[rd_ptr] : '0;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= next_ptr(wr_ptr);
            if (do_pop)
                rd_ptr <= next_ptr(rd_ptr);
            case ({push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    // NOTE: storage is deliberately not reset; an entry is only visible once count covers it.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/fp8_mul_arbiter.sv
// Two-requester round-robin front end for a shared fixed-latency FP8 vector
// multiplier, with credit flow control and an in-order response FIFO.
module fp8_mul_arbiter
    import fp8_mul_pkg::*;
#(
    parameter int LAT   = 2,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req_valid,
    output logic [NREQ-1:0]          req_ready,
    input  logic [NREQ-1:0]          req_mode,
    input  logic [NREQ*OPND_W-1:0]   req_data,
    output logic                     mul_in_valid,
    output logic                     mul_e5m2mode,
    output logic [OPND_W-1:0]        mul_opnd,
    input  logic                     mul_out_valid,
    input  logic [RES_W-1:0]         mul_result,
    output logic                     resp_valid,
    input  logic                     resp_ready,
    output logic                     resp_id,
    output logic [RES_W-1:0]         resp_data,
    output logic                     err_sticky
);

    localparam int CRD_W = $clog2(DEPTH + 1);

    logic [CRD_W-1:0] credits;
    logic             rr_ptr;
    logic [NREQ-1:0]  grant;
    logic             grant_id;
    logic             hs;
    logic             resp_pop;
    logic             issue_id;
    tag_t             tag_sr [LAT];
    tag_t             tag_out;
    logic             fifo_push;
    logic [ENTRY_W-1:0] head_data;

    // NOTE: grant is defaulted before any branch so no path leaves it unassigned (no latch).
    always_comb begin
        grant = '0;
        if (!rst && credits != '0) begin
            if (&req_valid)
                grant[rr_ptr] = 1'b1;
            else
                grant = req_valid;
        end
    end

    assign req_ready = grant;
    assign grant_id  = grant[1];
    assign hs        = |grant;
    assign resp_pop  = resp_valid & resp_ready;

    // Credits cover both in-flight operations and queued responses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            credits      <= CRD_W'(DEPTH);
            rr_ptr       <= 1'b0;
            mul_in_valid <= 1'b0;
            mul_e5m2mode <= 1'b0;
            mul_opnd     <= '0;
            issue_id     <= 1'b0;
        end else begin
            mul_in_valid <= hs;
            if (hs && !resp_pop)
                credits <= credits - 1'b1;
            else if (resp_pop && !hs)
                credits <= credits + 1'b1;
            if (hs) begin
                mul_opnd     <= req_data[grant_id*OPND_W +: OPND_W];
                mul_e5m2mode <= req_mode[grant_id];
                issue_id     <= grant_id;
                rr_ptr       <= ~grant_id;
            end
        end
    end

    // Tag pipe mirrors the multiplier latency so tag_out lines up with mul_out_valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < LAT; i++)
                tag_sr[i] <= '0;
            err_sticky <= 1'b0;
        end else begin
            tag_sr[0] <= tag_t'{valid: mul_in_valid, id: issue_id};
            for (int i = 1; i < LAT; i++)
                tag_sr[i] <= tag_sr[i-1];
            if (mul_out_valid != tag_out.valid)
                err_sticky <= 1'b1;
        end
    end

    assign tag_out   = tag_sr[LAT-1];
    assign fifo_push = mul_out_valid & tag_out.valid;

    fp8_resp_fifo #(
        .DEPTH (DEPTH)
    ) u_resp_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (fifo_push),
        .push_data  ({tag_out.id, mul_result}),
        .pop        (resp_ready),
        .head_valid (resp_valid),
        .head_data  (head_data)
    );

    assign resp_id   = head_data[RES_W];
    assign resp_data = head_data[RES_W-1:0];

endmodule

// File: tb/tb_fp8_mul_arbiter.sv
// Scoreboard bench for fp8_mul_arbiter: a stub multiplier, a round-robin and
// credit reference model, and an in-order expected-response queue.
module tb_fp8_mul_arbiter;
    import fp8_mul_pkg::*;

    localparam int LAT   = 2;
    localparam int DEPTH = 4;
    localparam logic [RES_W-1:0] CONST_RES = 96'h0001_0002_0003_0004_0005_0006;

    logic                   clk;
    logic                   rst;
    logic [NREQ-1:0]        req_valid;
    logic [NREQ-1:0]        req_ready;
    logic [NREQ-1:0]        req_mode;
    logic [NREQ*OPND_W-1:0] req_data;
    logic                   mul_in_valid;
    logic                   mul_e5m2mode;
    logic [OPND_W-1:0]      mul_opnd;
    logic                   mul_out_valid;
    logic [RES_W-1:0]       mul_result;
    logic                   resp_valid;
    logic                   resp_ready;
    logic                   resp_id;
    logic [RES_W-1:0]       resp_data;
    logic                   err_sticky;

    fp8_mul_arbiter #(.LAT(LAT), .DEPTH(DEPTH)) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_mode      (req_mode),
        .req_data      (req_data),
        .mul_in_valid  (mul_in_valid),
        .mul_e5m2mode  (mul_e5m2mode),
        .mul_opnd      (mul_opnd),
        .mul_out_valid (mul_out_valid),
        .mul_result    (mul_result),
        .resp_valid    (resp_valid),
        .resp_ready    (resp_ready),
        .resp_id       (resp_id),
        .resp_data     (resp_data),
        .err_sticky    (err_sticky)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Stub multiplier: fixed LAT-cycle pipe producing a recognisable function of its inputs.
    function automatic logic [RES_W-1:0] stub_fn(input logic [OPND_W-1:0] op, input logic m);
        return {(m ? 16'hE5E5 : 16'h4343), op, ~op};
    endfunction

    logic             stub_const;
    logic             stub_inject;
    logic             pipe_v [LAT];
    logic [RES_W-1:0] pipe_r [LAT];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < LAT; i++) pipe_v[i] <= 1'b0;
        end else begin
            pipe_v[0] <= mul_in_valid;
            pipe_r[0] <= stub_const ? CONST_RES : stub_fn(mul_opnd, mul_e5m2mode);
            for (int i = 1; i < LAT; i++) begin
                pipe_v[i] <= pipe_v[i-1];
                pipe_r[i] <= pipe_r[i-1];
            end
        end
    end

    assign mul_out_valid = pipe_v[LAT-1] | stub_inject;
    assign mul_result    = pipe_r[LAT-1];

    // Reference model state, sampled and updated on the falling edge.
    logic [RES_W:0]    exp_q [$];
    int                grant_log [$];
    int                outstanding;
    int                hs_count;
    logic              last_id;
    logic              iss_pend;
    logic [OPND_W-1:0] iss_opnd;
    logic              iss_mode;
    logic              hold_v;
    logic [RES_W:0]    hold_d;
    logic [1:0]        exp_rdy;
    logic [RES_W:0]    exp_e;
    logic [OPND_W-1:0] slice;

    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            outstanding = 0;
            last_id     = 1'b1;
            iss_pend    = 1'b0;
            hold_v      = 1'b0;
        end else begin
            exp_rdy = 2'b00;
            if (outstanding < DEPTH) begin
                if (req_valid == 2'b11)
                    exp_rdy = last_id ? 2'b01 : 2'b10;
                else
                    exp_rdy = req_valid;
            end
            check("req_ready", 128'(req_ready), 128'(exp_rdy));

            check("mul_in_valid", 128'(mul_in_valid), 128'(iss_pend));
            if (iss_pend) begin
                check("mul_opnd", 128'(mul_opnd), 128'(iss_opnd));
                check("mul_e5m2mode", 128'(mul_e5m2mode), 128'(iss_mode));
            end
            iss_pend = 1'b0;

            if (hold_v) begin
                check("resp_hold_valid", 128'(resp_valid), 128'(1));
                check("resp_hold_data", 128'({resp_id, resp_data}), 128'(hold_d));
            end
            hold_v = resp_valid & ~resp_ready;
            hold_d = {resp_id, resp_data};

            if (resp_valid && resp_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL resp_unexpected: got id=%0d data=%h expected no response", resp_id, resp_data);
                end else begin
                    exp_e = exp_q.pop_front();
                    check("resp", 128'({resp_id, resp_data}), 128'(exp_e));
                end
                outstanding--;
            end

            for (int i = 0; i < NREQ; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    slice = req_data[i*OPND_W +: OPND_W];
                    exp_q.push_back({1'(i), stub_const ? CONST_RES : stub_fn(slice, req_mode[i])});
                    iss_pend = 1'b1;
                    iss_opnd = slice;
                    iss_mode = req_mode[i];
                    last_id  = 1'(i);
                    outstanding++;
                    hs_count++;
                    grant_log.push_back(i);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        tick();
        req_valid = 2'b00;
        rst = 1'b1;
        @(negedge clk);
        tick();
        rst = 1'b0;
    endtask

    task automatic drain(input string name);
        int n;
        req_valid  = 2'b00;
        resp_ready = 1'b1;
        n = 0;
        while (outstanding != 0 && n < 200) begin
            tick();
            n++;
        end
        check(name, 128'(outstanding), 128'(0));
        resp_ready = 1'b0;
    endtask

    task automatic rand_data();
        req_data = {16'($urandom), $urandom, $urandom};
        req_mode = 2'($urandom);
    endtask

    int h0;
    int g0;
    int n;

    initial begin
        rst = 1'b1; req_valid = '0; req_mode = '0; req_data = '0;
        resp_ready = 1'b0; stub_const = 1'b0; stub_inject = 1'b0;
        hs_count = 0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_req_ready", 128'(req_ready), 128'(0));
        check("rst_mul_in_valid", 128'(mul_in_valid), 128'(0));
        check("rst_mul_opnd", 128'(mul_opnd), 128'(0));
        check("rst_resp_valid", 128'(resp_valid), 128'(0));
        check("rst_resp_data", 128'({resp_id, resp_data}), 128'(0));
        check("rst_err", 128'(err_sticky), 128'(0));
        rst = 1'b0;

        // Single request with a constant stub result and exact latency.
        tick();
        stub_const = 1'b1;
        req_data   = {40'h0, 8'h38, 8'h4C, 8'hC4, 8'h40, 8'hC8};
        req_mode   = 2'b00;
        req_valid  = 2'b01;
        tick();
        req_valid = 2'b00;
        for (int k = 1; k <= LAT + 2; k++) begin
            @(negedge clk);
            check($sformatf("latency_c%0d", k), 128'(resp_valid), 128'(k == LAT + 2));
        end
        check("single_resp_id", 128'(resp_id), 128'(0));
        check("single_resp_data", 128'(resp_data), 128'(96'h000100020003000400050006));
        tick();
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        stub_const = 1'b0;

        // Both requesters held valid: grants alternate starting at 0.
        do_reset();
        resp_ready = 1'b1;
        req_valid  = 2'b11;
        g0 = grant_log.size();
        n  = 0;
        while (grant_log.size() - g0 < 8 && n < 60) begin
            rand_data();
            tick();
            n++;
        end
        check("rr_grant_count", 128'(grant_log.size() - g0 >= 8), 128'(1));
        for (int k = 0; k < 8 && g0 + k < grant_log.size(); k++)
            check($sformatf("rr_grant_%0d", k), 128'(grant_log[g0+k]), 128'(k % 2));
        drain("rr_drain");

        // Credits: stalled responses allow exactly DEPTH issues, one pop frees one.
        do_reset();
        resp_ready = 1'b0;
        req_valid  = 2'b01;
        h0 = hs_count;
        repeat (12) begin
            rand_data();
            tick();
        end
        check("credit_limit", 128'(hs_count - h0), 128'(DEPTH));
        @(negedge clk);
        check("credit_ready_low", 128'(req_ready), 128'(0));
        tick();
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        repeat (12) tick();
        check("credit_one_more", 128'(hs_count - h0), 128'(DEPTH + 1));

        // Full FIFO released into continuous two-requester traffic.
        resp_ready = 1'b1;
        req_valid  = 2'b11;
        repeat (30) begin
            rand_data();
            tick();
        end
        drain("full_stream_drain");
        check("full_stream_queue", 128'(exp_q.size()), 128'(0));

        // Result strobe with no tag: sticky error, nothing queued.
        do_reset();
        stub_inject = 1'b1;
        tick();
        stub_inject = 1'b0;
        repeat (LAT + 3) tick();
        @(negedge clk);
        check("orphan_err", 128'(err_sticky), 128'(1));
        check("orphan_no_resp", 128'(resp_valid), 128'(0));
        do_reset();
        check("orphan_err_cleared", 128'(err_sticky), 128'(0));

        // Reset with three operations in flight.
        resp_ready = 1'b0;
        req_valid  = 2'b11;
        repeat (3) begin
            rand_data();
            tick();
        end
        #2;
        rst = 1'b1;
        #1;
        check("midrst_req_ready", 128'(req_ready), 128'(0));
        check("midrst_mul", 128'({mul_in_valid, mul_e5m2mode, mul_opnd}), 128'(0));
        check("midrst_resp", 128'({resp_valid, resp_id, resp_data}), 128'(0));
        check("midrst_err", 128'(err_sticky), 128'(0));
        @(negedge clk);
        tick();
        rst = 1'b0;
        h0 = hs_count;
        g0 = grant_log.size();
        repeat (12) tick();
        check("midrst_credits", 128'(hs_count - h0), 128'(DEPTH));
        if (grant_log.size() > g0)
            check("midrst_first_grant", 128'(grant_log[g0]), 128'(0));
        check("midrst_no_err", 128'(err_sticky), 128'(0));
        drain("midrst_drain");

        // Randomised traffic with random back-pressure.
        do_reset();
        repeat (400) begin
            rand_data();
            req_valid  = 2'($urandom);
            resp_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        drain("random_drain");
        check("random_queue", 128'(exp_q.size()), 128'(0));
        check("random_err", 128'(err_sticky), 128'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fp8_mul_arbiter.md
FP8_MUL_ARBITER -- requirements
Module: fp8_mul_arbiter

Interface
REQ-001 SHALL have parameter LAT, default 2: fixed multiplier latency in cycles from mul_in_valid to mul_out_valid.
REQ-002 SHALL have parameter DEPTH, default 4: response FIFO entries and issue credits.
REQ-003 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have port req_valid, input, 2: request valid per requester.
REQ-006 SHALL have port req_ready, output, 2: request accepted per requester.
REQ-007 SHALL have port req_mode, input, 2: per-requester e5m2 select (1 = E5M2, 0 = E4M3).
REQ-008 SHALL have port req_data, input, 80: per-requester {q,k,a,b,c}, 40 bits each; requester 0 in [39:0].
REQ-009 SHALL have port mul_in_valid, output, 1: issue strobe to the shared FP8 vector multiplier.
REQ-010 SHALL have port mul_e5m2mode, output, 1: format select to the multiplier.
REQ-011 SHALL have port mul_opnd, output, 40: {q,k,a,b,c} to the multiplier.
REQ-012 SHALL have port mul_out_valid, input, 1: multiplier result strobe.
REQ-013 SHALL have port mul_result, input, 96: {qa,qb,qc,ka,kb,kc}, 16 bits each.
REQ-014 SHALL have port resp_valid, output, 1: response available.
REQ-015 SHALL have port resp_ready, input, 1: response consumed.
REQ-016 SHALL have port resp_id, output, 1: requester that owns the response.
REQ-017 SHALL have port resp_data, output, 96: result payload.
REQ-018 SHALL have port err_sticky, output, 1: tag/strobe mismatch seen.

Function
REQ-019 SHALL grant at most one requester per cycle; req_ready[i] is combinational on req_valid, credits and priority; handshake = req_valid[i] & req_ready[i].
REQ-020 SHALL round-robin: when both valid, grant the requester not granted last; pointer updates only on a grant; a lone valid requester is granted regardless of the pointer.
REQ-021 SHALL grant nothing while credits = 0; credits decrement on a handshake, increment on a response handshake, and are unchanged when both occur in one cycle.
REQ-022 SHALL register the granted operands and mode; mul_in_valid is high exactly one cycle after each handshake, otherwise low, and mul_opnd/mul_e5m2mode hold their last value when idle.
REQ-023 SHALL carry {valid,id} through a LAT-stage tag shift register fed by mul_in_valid.
REQ-024 SHALL push {id,mul_result} into the FIFO when mul_out_valid and the tag output valid are both high.
REQ-025 SHALL set err_sticky on mul_out_valid without a tag, or on a tag without mul_out_valid, and discard the unmatched event without pushing.
REQ-026 SHALL present the FIFO head registered: resp_valid rises one cycle after a push into an empty FIFO; minimum request-to-response latency is LAT+2 cycles.
REQ-027 SHALL hold resp_data/resp_id stable while resp_valid & !resp_ready, and pop on resp_valid & resp_ready.
REQ-028 SHALL allow a push and a pop in the same cycle at any occupancy, including full; credits guarantee a push never occurs to a full FIFO.
REQ-029 SHALL return responses in issue order; FIFO pointers wrap modulo DEPTH.

Reset
REQ-030 SHALL on rst clear req_ready, mul_in_valid, mul_e5m2mode, mul_opnd, resp_valid, resp_id, resp_data, err_sticky, tags and FIFO pointers, set credits = DEPTH, and point priority at requester 0.
REQ-031 SHALL drop all in-flight work on reset mid-operation; the multiplier shares rst, so no stale result returns after reset.

Structure
REQ-032 SHALL take OPND_W=40, RES_W=96, NREQ=2 and the tag struct {valid,id} from shared package fp8_mul_pkg.
REQ-033 SHALL instantiate sub-module fp8_resp_fifo (DEPTH x 97 bits, registered head).

Verification
REQ-034 Single request: R0 data {q=0x38,k=0x4C,a=0xC4,b=0x40,c=0xC8}, mode 0 -> mul_in_valid next cycle with identical opnd; stub result 0x0001..0x0006 -> resp_id=0, resp_data=0x000100020003000400050006 at cycle LAT+2.
REQ-035 Both requesters held valid 8 cycles, resp_ready=1 -> grants alternate 0,1,0,1...; responses alternate ids in issue order.
REQ-036 resp_ready=0, R0 continuous -> exactly 4 handshakes, then req_ready=0; one pop -> exactly one more handshake.
REQ-037 FIFO full with resp_ready=1 and a push in the same cycle -> occupancy stays 4, no data lost or duplicated.
REQ-038 Stub asserts mul_out_valid with no tag -> err_sticky=1 until rst, no response produced.
REQ-039 rst asserted with 3 in flight -> all outputs 0 immediately; after release credits=4 and first grant goes to R0.
